// File: rtl/constants_pkg.sv
// Shared constants for the execute-stage control-flow logic: opcodes, branch
// funct3 encodings and the redirect handshake state type.
package constants_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        BR_IDLE    = 1'b0,
        BR_PENDING = 1'b1
    } br_state_e;

    // A target is misaligned when its two low bits are not zero.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/branch_resolve_decide.sv
// Combinational taken / is-branch / illegal decision from opcode, funct3 and
// the comparator flags.
module branch_decide
    import constants_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       breq_i,
    input  logic       brlt_i,
    output logic       taken_o,
    output logic       is_branch_o,
    output logic       illegal_o
);

    // Decode: jumps are always taken, funct3 010/011 branches are illegal.
    always_comb begin
        taken_o     = 1'b0;
        is_branch_o = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OPC_BRANCH: begin
                is_branch_o = 1'b1;
                case (funct3_i)
                    F3_BEQ:           taken_o = breq_i;
                    F3_BNE:           taken_o = !breq_i;
                    F3_BLT, F3_BLTU:  taken_o = brlt_i;
                    F3_BGE, F3_BGEU:  taken_o = !brlt_i;
                    default:          illegal_o = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                taken_o = 1'b1;
            end
            default: begin
                taken_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage control-flow resolution: target computation, registered
// redirect to fetch over valid/ready, flush pulse and branch statistics.
module branch_resolve
    import constants_pkg::*;
#(
    parameter int DWIDTH = DATA_WIDTH,
    parameter int AWIDTH = 32,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic              breq_i,
    input  logic              brlt_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] rs1_i,
    output logic              redirect_valid_o,
    input  logic              redirect_ready_i,
    output logic [AWIDTH-1:0] redirect_pc_o,
    output logic              flush_o,
    output logic              misaligned_o,
    output logic              illegal_branch_o,
    output logic [CWIDTH-1:0] branch_cnt_o,
    output logic [CWIDTH-1:0] taken_cnt_o
);

    br_state_e         r_state;
    br_state_e         w_state_next;
    logic [AWIDTH-1:0] r_redirect_pc;
    logic              r_misaligned;
    logic              r_illegal;
    logic [CWIDTH-1:0] r_branch_cnt;
    logic [CWIDTH-1:0] r_taken_cnt;

    logic              w_taken;
    logic              w_is_branch;
    logic              w_illegal;
    logic              w_accept;
    logic              w_load;
    logic              w_is_jalr;
    logic [AWIDTH-1:0] w_base;
    logic [AWIDTH-1:0] w_imm;
    logic [AWIDTH-1:0] w_sum;
    logic [AWIDTH-1:0] w_target;

    branch_decide u_decide (
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .breq_i      (breq_i),
        .brlt_i      (brlt_i),
        .taken_o     (w_taken),
        .is_branch_o (w_is_branch),
        .illegal_o   (w_illegal)
    );

    assign redirect_valid_o = (r_state == BR_PENDING);
    assign ready_o          = !redirect_valid_o || redirect_ready_i;
    assign flush_o          = redirect_valid_o && redirect_ready_i;
    assign w_accept         = valid_i && ready_o;
    assign w_load           = w_accept && w_taken;

    // JALR adds to rs1 and drops bit 0; everything else is PC-relative.
    assign w_is_jalr = (opcode_i == OPC_JALR);
    assign w_base    = w_is_jalr ? AWIDTH'(rs1_i) : pc_i;
    assign w_imm     = AWIDTH'($signed(imm_i));
    assign w_sum     = w_base + w_imm;
    assign w_target  = w_is_jalr ? {w_sum[AWIDTH-1:1], 1'b0} : w_sum;

    assign redirect_pc_o    = r_redirect_pc;
    assign misaligned_o     = r_misaligned;
    assign illegal_branch_o = r_illegal;
    assign branch_cnt_o     = r_branch_cnt;
    assign taken_cnt_o      = r_taken_cnt;

    // Redirect handshake state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a fresh taken instruction wins over retiring the old redirect.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BR_IDLE: begin
                if (w_load) begin
                    w_state_next = BR_PENDING;
                end else begin
                    w_state_next = BR_IDLE;
                end
            end
            BR_PENDING: begin
                if (w_load) begin
                    w_state_next = BR_PENDING;
                end else if (redirect_ready_i) begin
                    w_state_next = BR_IDLE;
                end else begin
                    w_state_next = BR_PENDING;
                end
            end
            default: begin
                w_state_next = BR_IDLE;
            end
        endcase
    end

    // Redirect payload and illegal-branch pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_pc <= {AWIDTH{1'b0}};
            r_misaligned  <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_illegal;
            if (w_load) begin
                r_redirect_pc <= w_target;
                r_misaligned  <= is_misaligned(w_target[1:0]);
            end
        end
    end

    // Statistics: conditional branches only, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_cnt <= {CWIDTH{1'b0}};
            r_taken_cnt  <= {CWIDTH{1'b0}};
        end else if (w_accept && w_is_branch) begin
            r_branch_cnt <= r_branch_cnt + {{(CWIDTH-1){1'b0}}, 1'b1};
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + {{(CWIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
